// File: rtl/cpu_clock_scheduler_pkg.sv
// Shared encodings for the CPU clock scheduler: front-panel mode select and scheduler state.
package cpu_clock_scheduler_pkg;

  typedef enum logic [1:0] {
    MODE_SLOW  = 2'b00,
    MODE_FULL  = 2'b01,
    MODE_STEP  = 2'b10,
    MODE_PAUSE = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_RUN    = 2'b00,
    ST_STEP   = 2'b01,
    ST_PAUSE  = 2'b10,
    ST_HALTED = 2'b11
  } state_e;

  function automatic state_e mode_target(input mode_e m);
    case (m)
      MODE_STEP:  return ST_STEP;
      MODE_PAUSE: return ST_PAUSE;
      default:    return ST_RUN;
    endcase
  endfunction

endpackage

// File: rtl/cpu_clock_scheduler_button_debounce.sv
// Push-button front end: 2-flop synchronizer, stability debounce, one-cycle pulse on accepted press.
module button_debounce #(
  parameter int unsigned DEBOUNCE = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic rise
);

  localparam logic [31:0] DEB_LAST = 32'(DEBOUNCE - 1);

  logic        sync1;
  logic        sync2;
  logic        level;
  logic        level_d;
  logic [31:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      level   <= 1'b0;
      level_d <= 1'b0;
      cnt     <= '0;
    end else begin
      sync1   <= btn;
      sync2   <= sync1;
      level_d <= level;
      // Any sample agreeing with the accepted level restarts the stability window.
      if (sync2 != level) begin
        if (cnt == DEB_LAST) begin
          level <= sync2;
          cnt   <= '0;
        end else begin
          cnt <= cnt + 32'd1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

  assign rise = level & ~level_d;

endmodule

// File: rtl/cpu_clock_scheduler.sv
// Generates the pipeline clock-enable from the board clock in slow/full/step/pause modes with sticky halt.
module cpu_clock_scheduler
  import cpu_clock_scheduler_pkg::*;
#(
  parameter int unsigned DIV_SLOW = 50000,
  parameter int unsigned DEBOUNCE = 100000
) (
  input  logic        primitive_clk,
  input  logic        rst,
  input  logic [1:0]  mode,
  input  logic        step_btn,
  input  logic        halt,
  input  logic        resume,
  output logic        cpu_en,
  output logic [1:0]  sched_state,
  output logic [31:0] step_count
);

  localparam logic [31:0] DIV_LAST = 32'(DIV_SLOW - 1);

  state_e      state;
  state_e      state_nxt;
  mode_e       mode_in;
  mode_e       mode_q;
  logic [31:0] div_cnt;
  logic        step_req;
  logic        run_slow;
  logic        div_due;
  logic        en_nxt;

  assign mode_in = mode_e'(mode);

  button_debounce #(.DEBOUNCE(DEBOUNCE)) u_step_btn (
    .clk  (primitive_clk),
    .rst  (rst),
    .btn  (step_btn),
    .rise (step_req)
  );

  always_ff @(posedge primitive_clk) begin
    if (rst) begin
      state <= ST_PAUSE;
      mode_q <= MODE_SLOW;
    end else begin
      state <= state_nxt;
      mode_q <= mode_in;
    end
  end

  // Enable qualification uses the registered state/mode, so a pulse due this
  // cycle is issued under the old state even when halt or mode changes now.
  always_comb begin
    state_nxt = mode_target(mode_in);
    run_slow  = 1'b0;
    div_due   = 1'b0;
    en_nxt    = 1'b0;
    if (halt || (state == ST_HALTED && !resume)) begin
      state_nxt = ST_HALTED;
    end
    case (state)
      ST_RUN: begin
        run_slow = (mode_q == MODE_SLOW);
        div_due  = run_slow && (div_cnt == DIV_LAST);
        en_nxt   = (mode_q == MODE_FULL) || div_due;
      end
      ST_STEP: en_nxt = step_req;
      default: en_nxt = 1'b0;
    endcase
  end

  always_ff @(posedge primitive_clk) begin
    if (rst) begin
      div_cnt    <= '0;
      cpu_en     <= 1'b0;
      step_count <= '0;
    end else begin
      if (run_slow && !div_due) begin
        div_cnt <= div_cnt + 32'd1;
      end else begin
        div_cnt <= '0;
      end
      cpu_en     <= en_nxt;
      step_count <= step_count + 32'(cpu_en);
    end
  end

  assign sched_state = state;

endmodule

// File: doc/cpu_clock_scheduler.md
Name: cpu_clock_scheduler

Overview:
- Sequences the pipeline CPU's execution rate from the single board clock.
- Emits a one-cycle clock-enable pulse (cpu_en) rather than a derived clock. The CPU datapath advances only on primitive_clk edges where cpu_en=1.
- Modes: slow divided run, full-speed run, debounced single-step, pause.
- Honours a sticky halt request from the CPU and counts issued steps for the display/debug logic.

Parameters:
- DIV_SLOW, 50000: slow-mode period in primitive_clk cycles; legal range 1..2^32-1.
- DEBOUNCE, 100000: cycles step_btn must be stable before its new level is accepted; legal range 1..2^32-1.

Ports:
- primitive_clk  in  1  board clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- mode  in  2  00 slow, 01 full, 10 single-step, 11 pause; level, sampled every cycle.
- step_btn  in  1  raw asynchronous push button.
- halt  in  1  CPU halt request (e.g. syscall exit); level.
- resume  in  1  clears halt; level.
- cpu_en  out  1  registered enable pulse to the pipeline.
- sched_state  out  2  00 RUN, 01 STEP, 10 PAUSE, 11 HALTED.
- step_count  out  32  number of cpu_en pulses issued since reset.

Behaviour:
- Reset (rst=1 at an edge):
  - cpu_en=0, sched_state=PAUSE, step_count=0.
  - Divider count=0; debounce count=0; synchronizer flops=0; stable button level=0.
  - Reset mid-run drops any in-flight pulse: cpu_en=0 on the next cycle.
- Button path:
  - 2-flop synchronizer into stable level btn_s.
  - Debounce counter increments while the synced raw value differs from btn_s.
  - It clears whenever the two are equal.
  - When the counter reaches DEBOUNCE-1, btn_s takes the new value and the counter clears.
  - step_req = one-cycle pulse on the 0->1 edge of btn_s.
- FSM (registered; target state is computed from the current inputs):
  - Any state with halt=1 -> HALTED. Halt has priority over mode.
  - HALTED stays until resume=1 and halt=0, then moves to the mode-selected state.
  - Otherwise the state follows mode: 00/01 -> RUN, 10 -> STEP, 11 -> PAUSE.
- Enable generation (cpu_en registered, one cycle after the qualifying condition):
  - RUN, mode=01: cpu_en=1 every cycle.
  - RUN, mode=00: divider counts 0..DIV_SLOW-1. Pulse when count==DIV_SLOW-1, then count wraps to 0. DIV_SLOW=1 is equivalent to full speed.
  - STEP: exactly one pulse per step_req. step_req arriving in other states is discarded and not queued.
  - PAUSE, HALTED: cpu_en=0.
  - The divider clears to 0 whenever the state is not RUN-slow, so the first slow pulse after entry occurs exactly DIV_SLOW cycles later.
- Simultaneous events:
  - halt=1 in the same cycle a pulse is due: the pulse is issued, then HALTED takes effect.
  - A mode change in the same cycle as a due pulse: the pulse follows the old state.
- step_count increments on every cycle with cpu_en=1 and wraps modulo 2^32 without a flag.
- Counter widths are 32 bits; comparisons are against PARAM-1 computed at elaboration.

Decomposition:
- Shared package holds:
  - mode encodings MODE_SLOW/FULL/STEP/PAUSE;
  - state encodings ST_RUN/STEP/PAUSE/HALTED.
- Sub-module button_debounce (synchronizer + debounce + rising-edge pulse), parameter DEBOUNCE.
  - Reusable for the other front-panel buttons.

Test Plan (DIV_SLOW=4, DEBOUNCE=3):
- Reset, then mode=01 -> cpu_en high every cycle from the 2nd cycle after the state reaches RUN; step_count=10 after 10 pulses.
- mode=00 for 20 cycles -> pulses exactly every 4 cycles, 5 pulses, first pulse 4 cycles after entering RUN.
- mode=10: glitchy step_btn (1-cycle highs), then a clean 10-cycle press -> the glitches produce no pulse; the clean press produces exactly one cpu_en; holding the button produces no further pulses.
- Full run with halt=1 on the same cycle as a due slow pulse -> that pulse issued, sched_state=HALTED, cpu_en=0 thereafter; a button press while halted is ignored; resume=1 returns to RUN.
- rst asserted mid slow count (count=2) -> outputs cleared next cycle, state PAUSE, step_count=0; after release with mode=00, first pulse 4 cycles after entering RUN.
- Force step_count to 0xFFFFFFFF via full-run preload (or a bench force) -> one more pulse wraps it to 0.
